w_load_ctrl: RTL

W_LOAD_CTRL -- requirements
Module: W_load_ctrl

---
 rtl/w_load_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/w_load_ctrl.sv
// Load controller between M and W stages: issues one word read per accepted load,
// then extracts and extends the addressed byte/halfword, with alignment and timeout checks.
module w_load_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_type,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a load request, ld_ready high
    // REQ   | mem_req high, waiting for mem_ack or timeout
    // RESP  | result held on out_data/out_err until out_ready

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] T_LW  = 3'b000;
    localparam logic [2:0] T_LB  = 3'b001;
    localparam logic [2:0] T_LBU = 3'b010;
    localparam logic [2:0] T_LH  = 3'b011;
    localparam logic [2:0] T_LHU = 3'b100;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    always_comb begin
        req_bad = 1'b0;
        case (ld_type)
            T_LW:         req_bad = (ld_addr[1:0] != 2'b00);
            T_LB, T_LBU:  req_bad = 1'b0;
            T_LH, T_LHU:  req_bad = ld_addr[0];
            default:      req_bad = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte = mem_rdata[{off_q, 3'b000} +: 8];
        sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_data = 32'd0;
        case (type_q)
            T_LW:    ext_data = mem_rdata;
            T_LB:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            T_LBU:   ext_data = {24'd0, sel_byte};
            T_LH:    ext_data = {{16{sel_half[15]}}, sel_half};
            T_LHU:   ext_data = {16'd0, sel_half};
            default: ext_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        off_d   = off_q;
        type_d  = type_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    addr_d = ld_addr[31:2];
                    off_d  = ld_addr[1:0];
                    type_d = ld_type;
                    if (req_bad) begin
                        state_d = RESP;
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 8'd0;
                    end
                end
            end
            REQ: begin
                // ack on the expiry cycle still counts as a normal response
                if (mem_ack) begin
                    state_d = RESP;
                    data_d  = ext_data;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 30'd0;
            off_q   <= 2'd0;
            type_q  <= 3'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            type_q  <= type_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign ld_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == REQ);
    assign out_valid = (state_q == RESP);
    assign mem_addr  = {addr_q, 2'b00};
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule
